// File: rtl/multi_tap_delay.sv
// rtl/multi_tap_delay.sv - shared ring buffer feeding TAPS independently delayed, validity-flagged read taps
// Optional: define MULTI_TAP_DELAY_FLUSH_EN to add a synchronous flush input (clears pointers and taps, not RAM).
module multi_tap_delay #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 1024,
    parameter int TAPS   = 4,
    parameter int SEL_W  = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
`ifdef MULTI_TAP_DELAY_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [WIDTH-1:0]      id,
    input  logic [TAPS*SEL_W-1:0] sel,
    output logic [TAPS*WIDTH-1:0] od,
    output logic [TAPS-1:0]       od_valid,
    output logic [SEL_W:0]        fill_cnt
);

    localparam logic [SEL_W:0] LEN_W  = (SEL_W+1)'(LENGTH);
    localparam logic [SEL_W:0] LAST_W = (SEL_W+1)'(LENGTH - 1);

    logic [WIDTH-1:0] mem [LENGTH];

    logic [SEL_W-1:0] wptr_q, wptr_d;
    logic [SEL_W:0]   fill_q, fill_d;
    logic [WIDTH-1:0] od_q [TAPS];
    logic [TAPS-1:0]  odv_q;

    logic [SEL_W:0]   dly_ext [TAPS];
    logic [SEL_W:0]   rd_ext  [TAPS];
    logic [SEL_W-1:0] rd_addr [TAPS];
    logic [TAPS-1:0]  tap_zero;
    logic [TAPS-1:0]  tap_ok;
    logic             wr_en;

    always_comb begin
        wr_en = ena;
`ifdef MULTI_TAP_DELAY_FLUSH_EN
        wr_en = ena && !flush;
`endif
    end

    always_comb begin
        wptr_d = (wptr_q == LAST_W[SEL_W-1:0]) ? '0 : wptr_q + 1'b1;
        fill_d = (fill_q == LEN_W) ? fill_q : fill_q + 1'b1;
    end

    // Clamp delay to LENGTH-1 and form the read address with an explicit wrap,
    // since LENGTH need not be a power of two.
    always_comb begin
        tap_zero = '0;
        tap_ok   = '0;
        for (int t = 0; t < TAPS; t++) begin
            dly_ext[t] = {1'b0, sel[t*SEL_W +: SEL_W]};
            if (dly_ext[t] > LAST_W) begin
                dly_ext[t] = LAST_W;
            end
            tap_zero[t] = (dly_ext[t] == '0);
            tap_ok[t]   = (fill_q >= dly_ext[t]);
            if ({1'b0, wptr_q} >= dly_ext[t]) begin
                rd_ext[t] = {1'b0, wptr_q} - dly_ext[t];
            end else begin
                rd_ext[t] = {1'b0, wptr_q} + LEN_W - dly_ext[t];
            end
            rd_addr[t] = rd_ext[t][SEL_W-1:0];
        end
    end

    // RAM kept free of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            fill_q <= '0;
            odv_q  <= '0;
            for (int t = 0; t < TAPS; t++) begin
                od_q[t] <= '0;
            end
        end else begin
`ifdef MULTI_TAP_DELAY_FLUSH_EN
            if (flush) begin
                wptr_q <= '0;
                fill_q <= '0;
                odv_q  <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    od_q[t] <= '0;
                end
            end else
`endif
            if (ena) begin
                wptr_q <= wptr_d;
                fill_q <= fill_d;
                for (int t = 0; t < TAPS; t++) begin
                    if (tap_zero[t]) begin
                        od_q[t]  <= id;
                        odv_q[t] <= 1'b1;
                    end else if (tap_ok[t]) begin
                        od_q[t]  <= mem[rd_addr[t]];
                        odv_q[t] <= 1'b1;
                    end else begin
                        od_q[t]  <= '0;
                        odv_q[t] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        od = '0;
        for (int t = 0; t < TAPS; t++) begin
            od[t*WIDTH +: WIDTH] = od_q[t];
        end
        od_valid = odv_q;
        fill_cnt = fill_q;
    end

endmodule
